uart_tx_with_parity: RTL
========================

Name: uart_tx_with_parity

Overview:
Serializing UART transmitter that feeds the team's parity-checking UART receiver.
- Accepts one W_IN-bit packet on a valid/ready handshake.
- Sends it as NUM_WORDS = W_IN/BITS_PER_WORD frames, least-significant word first.
- Each frame is: start bit, data bits LSB first, parity bit, stop bit.
- Framing and bit period match the receiver exactly, so tx can be looped straight into its rx.

Parameters:
CLOCKS_PER_PULSE, 4, clock cycles per bit period (system clock / baud); must be >= 2.
BITS_PER_WORD, 8, data bits per UART frame.
W_IN, 16, packet width; must be a nonzero multiple of BITS_PER_WORD.
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of the data bits); 1 = inverted XOR.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rstn  input  1  asynchronous active-low reset.
s_valid  input  1  upstream packet valid.
s_ready  output  1  block idle and able to accept a packet.
s_data  input  W_IN  packet; word k = s_data[k*BITS_PER_WORD +: BITS_PER_WORD].
tx  output  1  serial line, idle high.
busy  output  1  high while any frame is being transmitted.

Behaviour:
- Clock and reset: one clock (clk); reset (rstn) is asynchronous and active-low.
- Reset values: tx=1, s_ready=1, busy=0, state=IDLE, all counters=0, shift and parity registers=0.
- Reset mid-frame: tx returns to 1 asynchronously and the partial packet is discarded; no restart on release.
- Registers and counters:
  - shift_reg[W_IN]: holds the packet.
  - c_clocks: counts 0..CLOCKS_PER_PULSE-1.
  - c_bits: counts 0..BITS_PER_WORD-1.
  - c_words: counts 0..NUM_WORDS-1.
  - par: running XOR of the bits sent in the current frame.
  - Each counter is at least 1 bit wide, even when NUM_WORDS=1.
- All outputs are registered; s_ready = (state==IDLE) and busy = !s_ready.
- IDLE:
  - tx=1.
  - On s_valid && s_ready: latch s_data into shift_reg, clear counters and par, go to START.
  - s_data is ignored in all other states.
- START: tx=0 for CLOCKS_PER_PULSE cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0] for each bit period.
  - At the end of each period: shift_reg shifts right by 1, par ^= shift_reg[0], c_bits increments.
  - After bit BITS_PER_WORD-1: clear c_bits, go to PARITY.
- PARITY: tx = par ^ PARITY_ODD for one bit period, then go to END.
- END (stop bit):
  - tx=1 for one bit period.
  - If c_words != NUM_WORDS-1: increment c_words, clear par, go to START (no extra idle between frames of a packet).
  - Otherwise: clear c_words, go to IDLE.
- Latency: start bit appears on tx the cycle after the accepting handshake edge.
- Frame = (BITS_PER_WORD+3)*CLOCKS_PER_PULSE cycles; packet = NUM_WORDS times that.
- s_ready re-asserts in the first cycle after the last stop bit.
- Back-to-back packets: at least one extra tx=1 cycle between packets, i.e. the last stop bit lasts CLOCKS_PER_PULSE+1 cycles. This is accepted.
- s_valid with s_ready low: no effect; upstream must hold s_valid and s_data until s_ready.
- Only the bit-period counter transitions states; there are no other simultaneous-event cases.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, END}, shared with the receiver;
  - function parity_of(word, odd);
  - localparam helper for counter width, max(1, $clog2(n)).
- One natural sub-module, uart_baud_counter: counts 0..CLOCKS_PER_PULSE-1, with clear and an end-of-period pulse output. The receiver can reuse it later.

Test Plan:
1. Reset: hold rstn=0 -> tx=1, s_ready=1, busy=0; release, no s_valid -> outputs unchanged for 100 cycles.
2. Single packet, defaults, s_data=16'hA507 -> word 0x07 sent as 0,1,1,1,0,0,0,0,0, parity 1, stop 1; then word 0xA5 sent as 0,1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit held 4 cycles, 88 cycles total, s_ready returns on cycle 89.
3. PARITY_ODD=1, s_data=16'h0000 -> both parity bits = 1; data bits all 0.
4. Back-to-back: s_valid held high with 16'h1234 then 16'hFFFF -> second start bit begins exactly 1 cycle after the first packet's final stop period; s_valid ignored while busy.
5. Reset mid-DATA: assert rstn=0 during the third data bit -> tx=1 immediately, s_ready=1; new packet 16'h00FF after release transmits cleanly.
6. Loopback: tx into uart_with_rx_parity (same parameters), 50 random packets -> each m_data equals s_data, one m_valid pulse per packet, no parity rejects.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, counter sizing and parity helper.
// Imported by the transmitter, the baud counter and the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    END
  } uart_state_e;

  // Counters are never narrower than one bit, even for a count range of 1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic parity_of(input logic [63:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLOCKS_PER_PULSE-1 while enabled, wraps, and flags the last cycle.
// Written to be shared between the transmitter and the receiver.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 en,
  input  logic                                 clr,
  output logic [cnt_width(CLOCKS_PER_PULSE)-1:0] count,
  output logic                                 tick
);

  localparam int CW = cnt_width(CLOCKS_PER_PULSE);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
    end
  end

  assign count = count_reg;
  assign tick  = en && (count_reg == LAST);

endmodule

// File: rtl/uart_tx_with_parity.sv
// Packet-to-serial UART transmitter: splits a W_IN-bit packet into frames of
// start, LSB-first data, parity and stop bits, least-significant word first.
module uart_tx_with_parity
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_IN             = 16,
  parameter int PARITY_ODD       = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W_IN-1:0] s_data,
  output logic            tx,
  output logic            busy
);

  localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int CCW       = cnt_width(CLOCKS_PER_PULSE);
  localparam int CBW       = cnt_width(BITS_PER_WORD);
  localparam int CWW       = cnt_width(NUM_WORDS);
  localparam logic [CBW-1:0] LAST_BIT  = CBW'(BITS_PER_WORD - 1);
  localparam logic [CWW-1:0] LAST_WORD = CWW'(NUM_WORDS - 1);
  localparam logic           ODD       = (PARITY_ODD != 0);

  uart_state_e     state_reg, state_next;
  logic [W_IN-1:0] shift_reg, shift_next;
  logic [CBW-1:0]  c_bits_reg, c_bits_next;
  logic [CWW-1:0]  c_words_reg, c_words_next;
  logic            par_reg, par_next;
  logic            tx_reg, tx_next;
  logic            s_ready_reg, busy_reg;

  logic            accept;
  logic            tick;
  logic [CCW-1:0]  c_clocks;

  uart_baud_counter #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .en   (state_reg != IDLE),
    .clr  (accept),
    .count(c_clocks),
    .tick (tick)
  );

  assign accept = (state_reg == IDLE) && s_valid && s_ready_reg;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    c_bits_next  = c_bits_reg;
    c_words_next = c_words_reg;
    par_next     = par_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next   = s_data;
          c_bits_next  = '0;
          c_words_next = '0;
          par_next     = 1'b0;
          state_next   = START;
        end
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          par_next   = par_reg ^ shift_reg[0];
          if (c_bits_reg == LAST_BIT) begin
            c_bits_next = '0;
            state_next  = PARITY;
          end else begin
            c_bits_next = c_bits_reg + CBW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) state_next = END;
      end
      END: begin
        if (tick) begin
          if (c_words_reg != LAST_WORD) begin
            c_words_next = c_words_reg + CWW'(1);
            par_next     = 1'b0;
            state_next   = START;
          end else begin
            c_words_next = '0;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the next state so each bit lands exactly on its period boundary.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_of(64'(par_next), ODD);
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      c_bits_reg  <= '0;
      c_words_reg <= '0;
      par_reg     <= 1'b0;
      tx_reg      <= 1'b1;
      s_ready_reg <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      c_bits_reg  <= c_bits_next;
      c_words_reg <= c_words_next;
      par_reg     <= par_next;
      tx_reg      <= tx_next;
      s_ready_reg <= (state_next == IDLE);
      busy_reg    <= (state_next != IDLE);
    end
  end

  assign tx      = tx_reg;
  assign s_ready = s_ready_reg;
  assign busy    = busy_reg;

endmodule
